// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Purpose  : Packs field-level ops into RV32I words and streams them into
//             instruction RAM at consecutive word addresses (1-entry buffer).
//  Options  : define ENC_RANGE_CHECK_EN to reject immediates that do not fit.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        opcode,
    input  logic [3:0]        ctrl,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W-1:0] c_base = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_last = '1;

    localparam logic [0:0] c_st_run  = 1'b0;
    localparam logic [0:0] c_st_full = 1'b1;

    localparam logic [4:0] c_op_lui    = 5'b01101;
    localparam logic [4:0] c_op_auipc  = 5'b00101;
    localparam logic [4:0] c_op_jal    = 5'b11011;
    localparam logic [4:0] c_op_jalr   = 5'b11001;
    localparam logic [4:0] c_op_branch = 5'b11000;
    localparam logic [4:0] c_op_load   = 5'b00000;
    localparam logic [4:0] c_op_store  = 5'b01000;
    localparam logic [4:0] c_op_opimm  = 5'b00100;
    localparam logic [4:0] c_op_op     = 5'b01100;

    logic [0:0]        r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_err;

    logic [31:0] w_word;
    logic        w_known;
    logic        w_range_ok;
    logic        w_legal;
    logic [2:0]  w_f3;
    logic [6:0]  w_op7;
    logic        w_shift;
    logic        w_full;
    logic        w_ready;
    logic        w_accept;
    logic        w_complete;
    logic        w_going_full;

`ifdef ENC_RANGE_CHECK_EN
    logic w_fit12;
    logic w_fit13;
    logic w_fit21;

    // An immediate fits N signed bits when every bit above N-2 equals the sign.
    assign w_fit12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign w_fit13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign w_fit21 = (&imm[31:20]) | ~(|imm[31:20]);
`endif

    assign w_f3    = ctrl[2:0];
    assign w_op7   = {opcode, 2'b11};
    assign w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

    always_comb begin
        w_word     = '0;
        w_known    = 1'b1;
        w_range_ok = 1'b1;
        case (opcode)
            c_op_lui, c_op_auipc: begin
                w_word = {imm[31:12], rd, w_op7};
`ifdef ENC_RANGE_CHECK_EN
                w_range_ok = ~(|imm[11:0]);
`endif
            end
            c_op_jal: begin
                w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, w_op7};
`ifdef ENC_RANGE_CHECK_EN
                w_range_ok = w_fit21 & ~imm[0];
`endif
            end
            c_op_jalr: begin
                w_word = {imm[11:0], rs1, 3'b000, rd, w_op7};
`ifdef ENC_RANGE_CHECK_EN
                w_range_ok = w_fit12;
`endif
            end
            c_op_branch: begin
                w_word = {imm[12], imm[10:5], rs2, rs1, w_f3, imm[4:1], imm[11], w_op7};
`ifdef ENC_RANGE_CHECK_EN
                w_range_ok = w_fit13 & ~imm[0];
`endif
            end
            c_op_load: begin
                w_word = {imm[11:0], rs1, w_f3, rd, w_op7};
`ifdef ENC_RANGE_CHECK_EN
                w_range_ok = w_fit12;
`endif
            end
            c_op_store: begin
                w_word = {imm[11:5], rs2, rs1, w_f3, imm[4:0], w_op7};
`ifdef ENC_RANGE_CHECK_EN
                w_range_ok = w_fit12;
`endif
            end
            c_op_opimm: begin
                // Shifts carry the arithmetic/logical select in funct7[5].
                if (w_shift) begin
                    w_word = {1'b0, ctrl[3], 5'b0, imm[4:0], rs1, w_f3, rd, w_op7};
                end else begin
                    w_word = {imm[11:0], rs1, w_f3, rd, w_op7};
                end
`ifdef ENC_RANGE_CHECK_EN
                w_range_ok = w_fit12 & (~w_shift | ~(|imm[11:5]));
`endif
            end
            c_op_op: begin
                w_word = {1'b0, ctrl[3], 5'b0, rs2, rs1, w_f3, rd, w_op7};
            end
            default: begin
                w_known = 1'b0;
            end
        endcase
    end

    assign w_legal      = w_known & w_range_ok;
    assign w_full       = (r_state == c_st_full);
    assign w_ready      = ~w_full & (~r_we | mem_ready);
    assign w_accept     = in_valid & w_ready & ~start;
    assign w_complete   = r_we & mem_ready;
    assign w_going_full = w_complete & (r_addr == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_run;
            r_we    <= 1'b0;
            r_addr  <= c_base;
            r_wdata <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (start) begin
            r_state <= c_st_run;
            r_we    <= 1'b0;
            r_addr  <= c_base;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_complete) begin
                r_we    <= 1'b0;
                r_addr  <= r_addr + 1'b1;
                r_count <= r_count + 1'b1;
                if (w_going_full) begin
                    r_state <= c_st_full;
                end
            end
            // A bundle accepted on the edge that exhausts the space is discarded.
            if (w_accept) begin
                if (!w_legal) begin
                    r_err <= 1'b1;
                end else if (!w_going_full) begin
                    r_we    <= 1'b1;
                    r_wdata <= w_word;
                end
            end
        end
    end

    assign in_ready  = w_ready;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign count     = r_count;
    assign full      = w_full;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Purpose  : Self-checking bench for instr_encoder (directed + random vs model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_ready;
    logic [4:0]    opcode;
    logic [3:0]    ctrl;
    logic [4:0]    rd, rs1, rs2;
    logic [31:0]   imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [AW:0]   count;
    logic          full, err;

    int vectors     = 0;
    int miscompares = 0;

    bit          m_we, m_full, m_err;
    int          m_addr, m_count;
    logic [31:0] m_wdata;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .ctrl(ctrl), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .count(count), .full(full), .err(err)
    );

    function automatic bit fits(input logic [31:0] v, input int n);
        longint s;
        s = longint'($signed(v));
        return (s >= -(longint'(1) << (n - 1))) && (s < (longint'(1) << (n - 1)));
    endfunction

    // Reference assembler: places each RV32I field at its bit position.
    function automatic void ref_encode(input logic [4:0] opc, input logic [3:0] ctl,
                                       input logic [4:0] d, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [31:0] iv,
                                       output logic [31:0] w, output bit legal);
        logic [31:0] o, rdp, s1p, s2p, f3p, i12;
        bit known, rng;
        o     = {25'd0, opc, 2'b11};
        rdp   = 32'(d) << 7;
        f3p   = 32'(ctl[2:0]) << 12;
        s1p   = 32'(s1) << 15;
        s2p   = 32'(s2) << 20;
        w     = 32'd0;
        known = 1'b1;
        rng   = 1'b1;
        case (opc)
            5'b01101, 5'b00101: begin
                w = (iv & 32'hFFFF_F000) | rdp | o;
                rng = ((iv & 32'hFFF) == 0);
            end
            5'b11011: begin
                w = o | rdp | (iv & 32'h000F_F000) | (((iv >> 11) & 1) << 20)
                    | (((iv >> 1) & 32'h3FF) << 21) | (((iv >> 20) & 1) << 31);
                rng = fits(iv, 21) && !iv[0];
            end
            5'b11001: begin
                w = o | rdp | s1p | ((iv & 32'hFFF) << 20);
                rng = fits(iv, 12);
            end
            5'b11000: begin
                w = o | (((iv >> 11) & 1) << 7) | (((iv >> 1) & 32'hF) << 8) | f3p | s1p | s2p
                    | (((iv >> 5) & 32'h3F) << 25) | (((iv >> 12) & 1) << 31);
                rng = fits(iv, 13) && !iv[0];
            end
            5'b00000: begin
                w = o | rdp | f3p | s1p | ((iv & 32'hFFF) << 20);
                rng = fits(iv, 12);
            end
            5'b01000: begin
                w = o | ((iv & 32'h1F) << 7) | f3p | s1p | s2p | (((iv >> 5) & 32'h7F) << 25);
                rng = fits(iv, 12);
            end
            5'b00100: begin
                if (ctl[2:0] == 3'b001 || ctl[2:0] == 3'b101) begin
                    i12 = (32'(ctl[3]) << 10) | (iv & 32'h1F);
                    rng = fits(iv, 12) && (((iv >> 5) & 32'h7F) == 0);
                end else begin
                    i12 = iv & 32'hFFF;
                    rng = fits(iv, 12);
                end
                w = o | rdp | f3p | s1p | (i12 << 20);
            end
            5'b01100: begin
                w = o | rdp | f3p | s1p | s2p | (32'(ctl[3]) << 30);
            end
            default: known = 1'b0;
        endcase
`ifdef ENC_RANGE_CHECK_EN
        legal = known && rng;
`else
        legal = known;
`endif
    endfunction

    function automatic bit model_ready();
        return !m_full && (!m_we || mem_ready);
    endfunction

    // Advances the model by one clock using the inputs currently driven.
    function automatic void model_step();
        bit acc, lg;
        logic [31:0] w;
        acc = in_valid && model_ready();
        if (rst) begin
            m_we = 0; m_addr = 0; m_wdata = 0; m_count = 0; m_full = 0; m_err = 0;
        end else if (start) begin
            m_we = 0; m_addr = 0; m_count = 0; m_full = 0; m_err = 0;
        end else begin
            if (m_we && mem_ready) begin
                if (m_addr == DEPTH - 1) m_full = 1;
                m_addr  = (m_addr + 1) % DEPTH;
                m_count = m_count + 1;
                m_we    = 0;
            end
            if (acc) begin
                ref_encode(opcode, ctrl, rd, rs1, rs2, imm, w, lg);
                if (!lg) m_err = 1;
                else if (!m_full) begin
                    m_we = 1; m_wdata = w;
                end
            end
        end
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [4:0] o, input logic [3:0] c, input logic [4:0] d,
                              input logic [4:0] a, input logic [4:0] b, input logic [31:0] i);
        opcode = o; ctrl = c; rd = d; rs1 = a; rs2 = b; imm = i;
    endtask

    task automatic pulse_start();
        start = 1; in_valid = 0;
        cycle();
        start = 0;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; in_valid = 0; mem_ready = 0;
        set_bundle(5'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        cycle();
        cycle();
        rst = 0;
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b expected 0", mem_we); end
        vectors++; if (mem_addr !== '0) begin miscompares++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
        vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
        vectors++; if (err !== 1'b0 || full !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got err=%b full=%b expected 0/0", err, full); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_addi();
        pulse_start();
        set_bundle(5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5);
        in_valid = 1; mem_ready = 1;
        cycle();
        in_valid = 0;
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 4'd0) begin miscompares++; $display("FAIL addi_req: got we=%b addr=%0d expected 1/0", mem_we, mem_addr); end
        vectors++; if (mem_wdata !== 32'h0050_0093) begin miscompares++; $display("FAIL addi_word: got %h expected 00500093", mem_wdata); end
        cycle();
        vectors++; if (mem_we !== 1'b0 || mem_addr !== 4'd1 || count !== 5'd1) begin miscompares++; $display("FAIL addi_done: got we=%b addr=%0d count=%0d expected 0/1/1", mem_we, mem_addr, count); end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        mem_ready = 1; in_valid = 1;
        set_bundle(5'b01100, 4'b1000, 5'd3, 5'd1, 5'd2, 32'd0);
        cycle();
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 4'd0 || mem_wdata !== 32'h4020_81B3) begin miscompares++; $display("FAIL b2b_sub: got we=%b addr=%0d word=%h expected 1/0/402081b3", mem_we, mem_addr, mem_wdata); end
        set_bundle(5'b11000, 4'b0000, 5'd0, 5'd1, 5'd2, 32'd8);
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
        cycle();
        in_valid = 0;
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 4'd1 || mem_wdata !== 32'h0020_8463) begin miscompares++; $display("FAIL b2b_beq: got we=%b addr=%0d word=%h expected 1/1/00208463", mem_we, mem_addr, mem_wdata); end
        cycle();
        vectors++; if (count !== 5'd2 || mem_we !== 1'b0) begin miscompares++; $display("FAIL b2b_count: got count=%0d we=%b expected 2/0", count, mem_we); end
    endtask

    task automatic test_stall();
        pulse_start();
        mem_ready = 0; in_valid = 1;
        set_bundle(5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5);
        cycle();
        set_bundle(5'b01100, 4'b1000, 5'd3, 5'd1, 5'd2, 32'd0);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready[%0d]: got %b expected 0", i, in_ready); end
            cycle();
            vectors++; if (mem_we !== 1'b1 || mem_addr !== 4'd0 || mem_wdata !== 32'h0050_0093) begin miscompares++; $display("FAIL stall_hold[%0d]: got we=%b addr=%0d word=%h expected 1/0/00500093", i, mem_we, mem_addr, mem_wdata); end
        end
        mem_ready = 1;
        cycle();
        in_valid = 0;
        vectors++; if (mem_addr !== 4'd1 || count !== 5'd1 || mem_wdata !== 32'h4020_81B3) begin miscompares++; $display("FAIL stall_release: got addr=%0d count=%0d word=%h expected 1/1/402081b3", mem_addr, count, mem_wdata); end
        cycle();
        vectors++; if (count !== 5'd2) begin miscompares++; $display("FAIL stall_count: got %0d expected 2", count); end
    endtask

    task automatic test_illegal();
        pulse_start();
        mem_ready = 1; in_valid = 1;
        set_bundle(5'b11111, 4'b0000, 5'd1, 5'd2, 5'd3, 32'd0);
        cycle();
        vectors++; if (err !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 4'd0) begin miscompares++; $display("FAIL illegal: got err=%b we=%b addr=%0d expected 1/0/0", err, mem_we, mem_addr); end
        set_bundle(5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5);
        cycle();
        in_valid = 0;
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 4'd0 || mem_wdata !== 32'h0050_0093) begin miscompares++; $display("FAIL illegal_next: got we=%b addr=%0d word=%h expected 1/0/00500093", mem_we, mem_addr, mem_wdata); end
        cycle();
        vectors++; if (count !== 5'd1 || err !== 1'b1) begin miscompares++; $display("FAIL illegal_sticky: got count=%0d err=%b expected 1/1", count, err); end
    endtask

    task automatic test_full();
        pulse_start();
        mem_ready = 1; in_valid = 1;
        set_bundle(5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5);
        for (int i = 0; i < DEPTH + 3; i++) cycle();
        vectors++; if (full !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL full_flag: got full=%b in_ready=%b expected 1/0", full, in_ready); end
        vectors++; if (mem_addr !== 4'd0 || mem_we !== 1'b0 || count !== 5'(DEPTH)) begin miscompares++; $display("FAIL full_state: got addr=%0d we=%b count=%0d expected 0/0/%0d", mem_addr, mem_we, count, DEPTH); end
        pulse_start();
        vectors++; if (full !== 1'b0 || count !== 5'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL full_restart: got full=%b count=%0d in_ready=%b expected 0/0/1", full, count, in_ready); end
    endtask

    task automatic test_range();
        pulse_start();
        mem_ready = 1; in_valid = 1;
        set_bundle(5'b00100, 4'b0000, 5'd0, 5'd0, 5'd0, 32'h800);
        cycle();
        in_valid = 0;
`ifdef ENC_RANGE_CHECK_EN
        vectors++; if (err !== 1'b1 || mem_we !== 1'b0) begin miscompares++; $display("FAIL range_reject: got err=%b we=%b expected 1/0", err, mem_we); end
`else
        vectors++; if (mem_we !== 1'b1 || mem_wdata !== 32'h8000_0013 || err !== 1'b0) begin miscompares++; $display("FAIL range_trunc: got we=%b word=%h err=%b expected 1/80000013/0", mem_we, mem_wdata, err); end
`endif
        cycle();
    endtask

    task automatic test_random();
        logic [4:0] ops [9] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000,
                                5'b00000, 5'b01000, 5'b00100, 5'b01100};
        logic [31:0] iv;
        pulse_start();
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 3))
                0: iv = $urandom;
                1: iv = 32'($urandom_range(0, 4095)) - 32'd2048;
                2: iv = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
                default: iv = $urandom << 12;
            endcase
            set_bundle(($urandom_range(0, 15) == 0) ? 5'($urandom) : ops[$urandom_range(0, 8)],
                       4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), iv);
            in_valid  = ($urandom_range(0, 9) < 7);
            mem_ready = ($urandom_range(0, 9) < 7);
            start     = ($urandom_range(0, 49) == 0);
            #1;
            vectors++; if (in_ready !== model_ready()) begin miscompares++; $display("FAIL rnd_ready[%0d]: got %b expected %b", n, in_ready, model_ready()); end
            cycle();
            vectors++;
            if (mem_we !== m_we || mem_addr !== AW'(m_addr) || mem_wdata !== m_wdata ||
                count !== (AW+1)'(m_count) || full !== m_full || err !== m_err) begin
                miscompares++;
                $display("FAIL rnd_state[%0d]: got we=%b addr=%0d word=%h count=%0d full=%b err=%b expected %b/%0d/%h/%0d/%b/%b",
                         n, mem_we, mem_addr, mem_wdata, count, full, err,
                         m_we, m_addr, m_wdata, m_count, m_full, m_err);
            end
        end
        start = 0; in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_full();
        test_range();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
